// File: rtl/qmux_sequencer.sv
// qmux_sequencer: replays a loaded Q-opcode program onto the DataQMUX Q select.
// Optional feature: define QSEQ_LOOP_EN to let loop_i wrap the program back to entry 0.
module qmux_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int RPT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [3:0]       wr_op,
  input  logic [RPT_W-1:0] wr_rpt,
  input  logic             start,
  input  logic             abort,
  input  logic             loop_i,
  output logic [3:0]       q,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    pc
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [3:0] HALT = 4'b1111;
  localparam logic [3:0] NOP  = 4'b0000;
  state_t           state_q, state_d;
  logic [3:0]       q_q, q_d;
  logic [AW-1:0]    pc_q, pc_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             done_q, done_d;
  logic [RPT_W+3:0] mem [DEPTH];
  logic [3:0]       e_op;
  logic [RPT_W-1:0] e_rpt;
  logic             wrap, last, at_end;
  assign {e_op, e_rpt} = mem[pc_q];
  assign last   = rpt_q == e_rpt;
  assign at_end = pc_q == AW'(DEPTH - 1);
`ifdef QSEQ_LOOP_EN
  assign wrap = loop_i;
`else
  logic unused_loop;
  assign unused_loop = loop_i;
  assign wrap = 1'b0;
`endif
  assign q    = q_q;
  assign busy = state_q == RUN;
  assign done = done_q;
  assign pc   = pc_q;
  // Program store: only writable while not executing, so a running program cannot be altered.
  always_ff @(posedge clk) begin
    if (wr_en && state_q != RUN) mem[wr_addr] <= {wr_op, wr_rpt};
  end
  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      q_q     <= NOP;
      pc_q    <= '0;
      rpt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      pc_q    <= pc_d;
      rpt_q   <= rpt_d;
      done_q  <= done_d;
    end
  end
  // Next state: abort wins, then RUN issue/advance, then start from IDLE/DONE.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    pc_d    = pc_q;
    rpt_d   = rpt_q;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      if (state_q == RUN) begin
        q_d   = NOP;
        pc_d  = '0;
        rpt_d = '0;
      end
    end else if (state_q == RUN) begin
      if (e_op == HALT) begin
        q_d = NOP;
        if (wrap) begin
          pc_d  = '0;
          rpt_d = '0;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end else begin
        q_d = e_op;
        if (!last) begin
          rpt_d = rpt_q + 1'b1;
        end else begin
          rpt_d = '0;
          if (!at_end) begin
            pc_d = pc_q + 1'b1;
          end else if (wrap) begin
            pc_d = '0;
          end else begin
            state_d = DONE;
            done_d  = 1'b1;
          end
        end
      end
    end else if (start) begin
      state_d = RUN;
      pc_d    = '0;
      rpt_d   = '0;
    end else if (state_q == DONE) begin
      q_d = NOP;
    end
  end
endmodule
